// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: writeback result select, load funct3 codes, x0 index.
package riscv_pkg;

  localparam int unsigned RES_SRC_W = 2;
  localparam int unsigned F3_W      = 3;
  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [RES_SRC_W-1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_t;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_extend.sv
// Load byte/half extraction with sign or zero extension; unknown funct3 passes the word.
module load_extend
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_off,
  input  logic [F3_W-1:0]       i_funct3,
  output logic [DATA_WIDTH-1:0] o_word_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Half select ignores off[0]; misaligned halves fold onto the aligned one.
  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_word_c = i_rdata;
    case (i_funct3)
      F3_LB:   o_word_c = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_LH:   o_word_c = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      F3_LBU:  o_word_c = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_LHU:  o_word_c = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: o_word_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// W-stage result select, integer register file with write-first read bypass, retire counter.
// Optional macro WB_RETIRE_CNT_EN builds the retired-instruction counter; otherwise it reads 0.
module writeback_regfile
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidW,
  input  logic                  RegWriteW,
  input  logic [RES_SRC_W-1:0]  ResultSrcW,
  input  logic [F3_W-1:0]       Funct3W,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic [DATA_WIDTH-1:0] ALUResultW,
  input  logic [DATA_WIDTH-1:0] ReadDataW,
  input  logic [DATA_WIDTH-1:0] PCPlus4W,
  input  logic [DATA_WIDTH-1:0] ImmExtW,
  input  logic [ADDR_WIDTH-1:0] A1D,
  input  logic [ADDR_WIDTH-1:0] A2D,
  output logic [DATA_WIDTH-1:0] RD1D,
  output logic [DATA_WIDTH-1:0] RD2D,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [CNT_WIDTH-1:0]  RetiredCnt
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] r_regs [NREGS];
  logic [DATA_WIDTH-1:0] w_load;
  logic                  w_we;

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .i_rdata  (ReadDataW),
    .i_off    (ALUResultW[1:0]),
    .i_funct3 (Funct3W),
    .o_word_c (w_load)
  );

  always_comb begin
    ResultW = ALUResultW;
    case (result_src_t'(ResultSrcW))
      RES_ALU:  ResultW = ALUResultW;
      RES_LOAD: ResultW = w_load;
      RES_PC4:  ResultW = PCPlus4W;
      RES_IMM:  ResultW = ImmExtW;
      default:  ResultW = ALUResultW;
    endcase
  end

  assign w_we = ValidW & RegWriteW & (RdW != ZERO_IDX);

  // x0 is never written, so its entry stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '{default: '0};
    end else if (w_we) begin
      r_regs[RdW] <= ResultW;
    end
  end

  // Write-first read ports; reset forces zero so stale bypass data cannot escape.
  always_comb begin
    RD1D = r_regs[A1D];
    RD2D = r_regs[A2D];
    if (w_we && (A1D == RdW)) RD1D = ResultW;
    if (w_we && (A2D == RdW)) RD2D = ResultW;
    if (rst || (A1D == ZERO_IDX)) RD1D = '0;
    if (rst || (A2D == ZERO_IDX)) RD2D = '0;
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] r_retired_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired_cnt <= '0;
    end else if (ValidW) begin
      r_retired_cnt <= r_retired_cnt + CNT_WIDTH'(1);
    end
  end

  assign RetiredCnt = r_retired_cnt;
`else
  assign RetiredCnt = '0;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized + directed bench for writeback_regfile against an array-based reference model.
module tb_writeback_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          ValidW, RegWriteW;
  logic [1:0]    ResultSrcW;
  logic [2:0]    Funct3W;
  logic [AW-1:0] RdW, A1D, A2D;
  logic [DW-1:0] ALUResultW, ReadDataW, PCPlus4W, ImmExtW;
  logic [DW-1:0] RD1D, RD2D, ResultW;
  logic [CW-1:0] RetiredCnt;

  logic [DW-1:0] ref_regs [32];
  logic [CW-1:0] ref_cnt;
  int unsigned   n_cmp = 0;
  int unsigned   n_mis = 0;

  writeback_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .Funct3W(Funct3W), .RdW(RdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .ImmExtW(ImmExtW), .A1D(A1D), .A2D(A2D), .RD1D(RD1D), .RD2D(RD2D),
    .ResultW(ResultW), .RetiredCnt(RetiredCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Load value computed arithmetically from the memory word.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_result();
    case (ResultSrcW)
      2'd0:    return ALUResultW;
      2'd1:    return model_load(ReadDataW, ALUResultW[1:0], Funct3W);
      2'd2:    return PCPlus4W;
      default: return ImmExtW;
    endcase
  endfunction

  function automatic logic model_we();
    return ValidW && RegWriteW && (RdW != 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    if (rst || a == 0) return 32'd0;
    if (model_we() && a == RdW) return model_result();
    return ref_regs[a];
  endfunction

  function automatic logic [63:0] model_cnt();
`ifdef WB_RETIRE_CNT_EN
    return ref_cnt;
`else
    return 64'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    ref_cnt = '0;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] f3,
                       input logic [AW-1:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ValidW = v; RegWriteW = rw; ResultSrcW = src; Funct3W = f3; RdW = rd;
    ALUResultW = alu; ReadDataW = rdata; A1D = a1; A2D = a2;
    PCPlus4W = 32'h0000_1004; ImmExtW = 32'hABCD_E000;
  endtask

  task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    drive(1'b0, 1'b0, 2'd0, 3'd2, '0, '0, '0, a1, a2);
  endtask

  // Compare every output against the model at the negedge.
  task automatic check_all(input string tag);
    @(negedge clk);
    check({tag, ".ResultW"},    64'(ResultW),  64'(model_result()));
    check({tag, ".RD1D"},       64'(RD1D),     64'(model_read(A1D)));
    check({tag, ".RD2D"},       64'(RD2D),     64'(model_read(A2D)));
    check({tag, ".RetiredCnt"}, RetiredCnt,    model_cnt());
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (model_we()) ref_regs[RdW] = model_result();
      if (ValidW) ref_cnt = ref_cnt + 64'd1;
    end
    #1;
  endtask

  initial begin
    logic [63:0] cnt_before;
    rst = 1'b1;
    model_reset();
    idle('0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state over every address.
    for (int i = 0; i < 32; i++) begin
      A1D = AW'(i); A2D = AW'(31 - i);
      #1;
      check("rst.RD1D", 64'(RD1D), 64'd0);
      check("rst.RD2D", 64'(RD2D), 64'd0);
    end
    check("rst.cnt", RetiredCnt, 64'd0);
    tick();

    // Same-cycle bypass then array read.
    drive(1'b1, 1'b1, 2'd0, 3'd2, 5'd5, 32'hDEAD_BEEF, '0, 5'd5, 5'd0);
    check_all("byp");
    check("byp.const", 64'(RD1D), 64'hDEAD_BEEF);
    tick();
    idle(5'd5, 5'd5);
    check_all("arr");
    check("arr.const", 64'(RD2D), 64'hDEAD_BEEF);
    tick();

    // Load extraction cases.
    drive(1'b0, 1'b0, 2'd1, 3'd0, '0, 32'd3, 32'h80FF_7F01, '0, '0);
    #1 check("lb.off3", 64'(ResultW), 64'hFFFF_FF80);
    drive(1'b0, 1'b0, 2'd1, 3'd4, '0, 32'd1, 32'h80FF_7F01, '0, '0);
    #1 check("lbu.off1", 64'(ResultW), 64'h0000_007F);
    drive(1'b0, 1'b0, 2'd1, 3'd1, '0, 32'd2, 32'h80FF_7F01, '0, '0);
    #1 check("lh.off2", 64'(ResultW), 64'hFFFF_80FF);
    drive(1'b0, 1'b0, 2'd1, 3'd5, '0, 32'd0, 32'h80FF_7F01, '0, '0);
    #1 check("lhu.off0", 64'(ResultW), 64'h0000_7F01);
    drive(1'b0, 1'b0, 2'd1, 3'd7, '0, 32'd1, 32'h80FF_7F01, '0, '0);
    #1 check("f3.undef", 64'(ResultW), 64'h80FF_7F01);
    tick();

    // Write to x0 is dropped.
    drive(1'b1, 1'b1, 2'd0, 3'd2, 5'd0, 32'h1234, '0, 5'd0, 5'd0);
    check_all("x0w");
    tick();
    idle(5'd0, 5'd0);
    check_all("x0r");
    tick();

    // Bubble with RegWrite set must not write or retire.
    cnt_before = model_cnt();
    drive(1'b0, 1'b1, 2'd0, 3'd2, 5'd7, 32'h55, '0, 5'd7, 5'd7);
    check_all("bub");
    tick();
    idle(5'd7, 5'd5);
    check_all("bub.after");
    check("bub.x7", 64'(RD1D), 64'd0);
    check("bub.cnt", RetiredCnt, cnt_before);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'd0, 3'd2, 5'd5, 32'h99, '0, 5'd5, 5'd7);
      check_all("store");
      tick();
    end
    idle(5'd5, 5'd7);
    check_all("store.after");
`ifdef WB_RETIRE_CNT_EN
    check("store.cnt3", RetiredCnt, cnt_before + 64'd3);
`else
    check("store.cnt0", RetiredCnt, 64'd0);
`endif
    tick();

    // Reset mid-stream discards the in-flight write.
    drive(1'b1, 1'b1, 2'd0, 3'd2, 5'd9, 32'h11, '0, 5'd9, 5'd9);
    tick();
    drive(1'b1, 1'b1, 2'd0, 3'd2, 5'd9, 32'h22, '0, 5'd9, 5'd5);
    #2 rst = 1'b1;
    model_reset();
    check_all("midrst");
    tick();
    #1 rst = 1'b0;
    idle(5'd9, 5'd5);
    check_all("postrst");
    check("postrst.x9", 64'(RD1D), 64'd0);
    tick();

    // Randomized traffic with address reuse to exercise bypass collisions.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] rd, a1, a2;
      rd = AW'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? rd : AW'($urandom);
      a2 = ($urandom_range(0, 2) == 0) ? rd : AW'($urandom);
      drive(1'($urandom_range(0, 4) != 0), 1'($urandom), 2'($urandom), 3'($urandom),
            rd, $urandom, $urandom, a1, a2);
      PCPlus4W = $urandom; ImmExtW = $urandom;
      check_all("rnd");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
